flag_unit: RTL
==============

# flag_unit

Parametrised, pipelined condition-flag unit for the execute/memory boundary of the 5-stage core. It splits a WIDTH-bit ALU result into GROUP-bit leaves and zero-detects each leaf. An optional register sits between the leaf stage and the final AND. The unit produces per-result zero/negative outputs for CBZ-style branches, and it maintains the architectural NZCV register, which updates only on flag-setting instructions. It replaces the fixed 64-bit purely combinational zero detector and adds a valid/flush pipeline.

## Interface
- WIDTH, 64, result width; must be a multiple of GROUP.
- GROUP, 16, bits per leaf zero-detector; WIDTH/GROUP leaves.
- PIPE, 1, 0 = no leaf register, 1 = one register between the leaf stage and the final AND.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  result/carry/overflow/set_flags are meaningful this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  ALU carry out.
- overflow_in  in  1  ALU signed overflow.
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- flush  in  1  kill all in-flight entries (branch mispredict).
- out_valid  out  1  zero/negative correspond to an accepted input.
- zero  out  1  result was all zeros (registered).
- negative  out  1  result[WIDTH-1] (registered).
- flags  out  4  architectural {N,Z,C,V}.
- flags_wr  out  1  one-cycle pulse: flags changed this cycle.

## Operation
- Leaf stage: leaf_zero[i] = ~|result[i*GROUP +: GROUP], for i = 0..WIDTH/GROUP-1.
  - If PIPE=1, the following are registered together as stage S1:
    - leaf_zero, result[WIDTH-1], carry_in, overflow_in, set_flags, and in_valid as s1_valid.
  - If PIPE=0, these pass straight through to S2.
- Final stage S2 (always registered):
  - zero <= &leaf_zero
  - negative <= sign
  - out_valid <= s1_valid & ~flush
- Flag write, on the same edge as S2: if the S2-bound entry is valid, not flushed, and has set_flags=1, then:
  - flags <= {sign, &leaf_zero, carry, overflow}
  - flags_wr <= 1
  - Otherwise flags holds and flags_wr <= 0.
- zero/negative update on every valid entry, whatever set_flags is. When out_valid=0 they hold their last value.
- flush:
  - Clears s1_valid and suppresses the S2 capture in the same cycle. With PIPE=0 this kills the same-cycle input.
  - Never alters flags.
  - When flush and in_valid coincide, flush wins: the new input is also dropped (s1_valid <= 0).
- reset:
  - flags=4'b0000; zero=0; negative=0; out_valid=0; flags_wr=0; s1_valid=0.
  - Reset mid-operation discards all in-flight entries, with no partial flag write.
  - Reset beats flush and in_valid.
- Width rules: WIDTH%GROUP != 0 is illegal and the elaboration-time check must fail. WIDTH=GROUP (single leaf) is legal.

## Timing
- Latency from in_valid to out_valid/zero/negative/flags: PIPE+1 rising edges. That is 2 cycles with the default PIPE=1, and 1 cycle with PIPE=0.
- Throughput: one result per cycle; no back-pressure, no stall input.
- Back-to-back set_flags entries produce consecutive flags_wr pulses, and flags updates every cycle.
- An entry accepted at edge k (PIPE=1) with flush asserted at edge k+1 produces no out_valid and no flag write.
- A flush at edge k+2 has no effect on that entry: it has already committed.
- All outputs change only on rising clk edges. There are no combinational in-to-out paths.
- The critical path is one GROUP-wide reduction (leaf stage) or one WIDTH/GROUP-input AND (S2).

## Test plan
- Reset: hold reset 2 cycles while driving in_valid=1, result=0, set_flags=1.
  - Required: flags=0000, zero=0, out_valid=0, flags_wr=0 throughout.
  - The first post-reset accepted entry appears 2 edges later.
- Zero detect per leaf (WIDTH=64, GROUP=16, PIPE=1, set_flags=1):
  - result=0 → zero=1, flags=0100.
  - result=64'h0001_0000_0000_0000 → zero=0.
  - result=64'h0000_0000_0004_0000 → zero=0.
  - result=64'h8000_0000_0000_0000 with carry=1 → flags=1010.
  - Each result appears exactly 2 cycles after its input.
- set_flags gating: result=0 with set_flags=0 after flags=1010.
  - Required: zero=1, out_valid=1, flags stays 1010, flags_wr=0.
- Flush: issue result=0 (set_flags=1) and assert flush on the next cycle.
  - Required: no out_valid, no flags_wr, flags unchanged.
  - flush coincident with in_valid also drops that input.
- Streaming: 8 consecutive results alternating 0 / 64'hFFFF_FFFF_FFFF_FFFF, all with set_flags=1.
  - Required: zero toggles 1,0,… and flags toggles 0100/1000, each 2 cycles after its input.
  - flags_wr is high for 8 consecutive cycles.
- Parameter sweep: repeat the zero-detect scenario for (WIDTH=32, GROUP=8, PIPE=0) and (WIDTH=16, GROUP=16, PIPE=1).
  - Required: identical flag values, latency 1 and 2 respectively.

Source files
------------

// File: rtl/flag_unit_if.sv
// Result/flag bus between the execute/memory boundary and the condition-flag unit.
// The master drives one ALU result per cycle; the slave returns zero/negative and NZCV.
interface flag_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             carry_in;
    logic             overflow_in;
    logic             set_flags;
    logic             flush;
    logic             out_valid;
    logic             zero;
    logic             negative;
    logic [3:0]       flags;
    logic             flags_wr;

    modport master (
        output in_valid, result, carry_in, overflow_in, set_flags, flush,
        input  out_valid, zero, negative, flags, flags_wr
    );

    modport slave (
        input  in_valid, result, carry_in, overflow_in, set_flags, flush,
        output out_valid, zero, negative, flags, flags_wr
    );
endinterface

// File: rtl/flag_unit.sv
// Pipelined condition-flag unit: per-leaf zero detect, optional leaf register (PIPE),
// registered zero/negative and the architectural NZCV register with flush and reset.
module flag_unit #(
    parameter int WIDTH = 64,
    parameter int GROUP = 16,
    parameter int PIPE  = 1
) (
    input  logic  clk,
    input  logic  reset,
    flag_if.slave bus
);
    localparam int LEAVES = WIDTH / GROUP;

    generate
        if (WIDTH % GROUP != 0) begin : g_bad_width
            $error("flag_unit: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
        end
    endgenerate

    logic [LEAVES-1:0] leaf_zero;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        leaf_zero = '0;
        for (int i = 0; i < LEAVES; i++) begin
            leaf_zero[i] = ~|bus.result[i*GROUP +: GROUP];
        end
    end

    logic [LEAVES-1:0] s1_leaf;
    logic              s1_sign;
    logic              s1_carry;
    logic              s1_ovf;
    logic              s1_set;
    logic              s1_valid;

    generate
        if (PIPE != 0) begin : g_s1
            logic [LEAVES-1:0] s1_leaf_q, s1_leaf_d;
            logic              s1_sign_q, s1_sign_d;
            logic              s1_carry_q, s1_carry_d;
            logic              s1_ovf_q, s1_ovf_d;
            logic              s1_set_q, s1_set_d;
            logic              s1_valid_q, s1_valid_d;

            always_comb begin
                s1_valid_d = bus.in_valid & ~bus.flush;
                s1_leaf_d  = leaf_zero;
                s1_sign_d  = bus.result[WIDTH-1];
                s1_carry_d = bus.carry_in;
                s1_ovf_d   = bus.overflow_in;
                s1_set_d   = bus.set_flags;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                end
            end

            // NOTE: payload flops are not reset; s1_valid_q qualifies every use of them downstream.
            always_ff @(posedge clk) begin
                s1_leaf_q  <= s1_leaf_d;
                s1_sign_q  <= s1_sign_d;
                s1_carry_q <= s1_carry_d;
                s1_ovf_q   <= s1_ovf_d;
                s1_set_q   <= s1_set_d;
            end

            assign s1_leaf  = s1_leaf_q;
            assign s1_sign  = s1_sign_q;
            assign s1_carry = s1_carry_q;
            assign s1_ovf   = s1_ovf_q;
            assign s1_set   = s1_set_q;
            assign s1_valid = s1_valid_q;
        end else begin : g_s1_bypass
            // Same-cycle flush is applied once, at the S2 capture below.
            assign s1_leaf  = leaf_zero;
            assign s1_sign  = bus.result[WIDTH-1];
            assign s1_carry = bus.carry_in;
            assign s1_ovf   = bus.overflow_in;
            assign s1_set   = bus.set_flags;
            assign s1_valid = bus.in_valid;
        end
    endgenerate

    logic       out_valid_q, out_valid_d;
    logic       zero_q, zero_d;
    logic       negative_q, negative_d;
    logic [3:0] flags_q, flags_d;
    logic       flags_wr_q, flags_wr_d;

    always_comb begin
        out_valid_d = s1_valid & ~bus.flush;
        zero_d      = zero_q;
        negative_d  = negative_q;
        flags_d     = flags_q;
        flags_wr_d  = 1'b0;
        if (out_valid_d) begin
            zero_d     = &s1_leaf;
            negative_d = s1_sign;
            if (s1_set) begin
                flags_d    = {s1_sign, &s1_leaf, s1_carry, s1_ovf};
                flags_wr_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            flags_q     <= 4'b0000;
            flags_wr_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            flags_q     <= flags_d;
            flags_wr_q  <= flags_wr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.flags     = flags_q;
    assign bus.flags_wr  = flags_wr_q;
endmodule
